// File: rtl/reset_sequencer_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rseq_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_areset_synchronizer.sv
// Reset synchronizer: asserts asynchronously, deasserts after EXTRA_STAGES+1 clock edges.
module areset_synchronizer #(
  parameter int   EXTRA_STAGES = 1,
  parameter logic ACTIVE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic areset,
  output logic rst_sync
);

  localparam int N = EXTRA_STAGES + 1;

  logic [N-1:0] sync_q;

  generate
    if (ACTIVE_LEVEL == 1'b0) begin : g_active_low
      always_ff @(posedge clk or negedge areset) begin
        if (!areset) sync_q <= {N{ACTIVE_LEVEL}};
        else         sync_q <= N'({sync_q, ~ACTIVE_LEVEL});
      end
    end else begin : g_active_high
      always_ff @(posedge clk or posedge areset) begin
        if (areset) sync_q <= {N{ACTIVE_LEVEL}};
        else        sync_q <= N'({sync_q, ~ACTIVE_LEVEL});
      end
    end
  endgenerate

  assign rst_sync = sync_q[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold all outputs, then release one per gap interval in index order.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int   STAGES       = 3,
  parameter int   HOLD_CYCLES  = 16,
  parameter int   GAP_CYCLES   = 4,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req,
  output logic [STAGES-1:0] rst_out,
  output logic              done
);

  localparam int CNT_W = width_for(max_int(HOLD_CYCLES, GAP_CYCLES));
  localparam int IDX_W = width_for(STAGES);

  localparam logic [STAGES-1:0] ALL_ON    = {STAGES{ACTIVE_LEVEL}};
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);

  logic rst_n;

  rseq_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              done_q, done_d;

  areset_synchronizer #(
    .EXTRA_STAGES (1),
    .ACTIVE_LEVEL (1'b0)
  ) u_areset_sync (
    .clk      (clk),
    .areset   (areset),
    .rst_sync (rst_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;

    if (req) begin
      // Software request restarts the whole sequence from full assertion.
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = ALL_ON;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            rst_d[0] = ~ACTIVE_LEVEL;
            cnt_d    = '0;
            if (STAGES == 1) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d   = IDX_W'(1);
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < STAGES; i++) begin
              if (idx_q == IDX_W'(i)) rst_d[i] = ~ACTIVE_LEVEL;
            end
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RUN: begin
          state_d = RUN;
        end

        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = ALL_ON;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Every register clears asynchronously, so outputs assert the moment areset falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= ALL_ON;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign rst_out = rst_q;
  assign done    = done_q;

endmodule
